rt_sba_obi_arbiter: RTL and testbench

//  Shares the RT subsystem's single OBI system-bus manager port between NumReq requesters
//  (port 0: debug-module SBA master, port 1: boot/ELF loader DMA).

---
 rtl/rt_pkg.sv | 30 +++
 rtl/rt_id_fifo.sv | 72 +++++++
 rtl/rt_sba_obi_arbiter.sv | 138 +++++++++++++
 tb/tb_rt_sba_obi_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and constants for the RT system-bus arbiter
package rt_pkg;

    localparam int unsigned RtNumReq         = 2;
    localparam int unsigned RtAddrWidth      = 32;
    localparam int unsigned RtDataWidth      = 32;
    localparam int unsigned RtMaxOutstanding = 4;

    // Requester port assignment on the shared manager port
    localparam int unsigned DbgSba = 0;
    localparam int unsigned Loader = 1;

    typedef struct packed {
        logic [RtAddrWidth-1:0]   addr;
        logic                     we;
        logic [RtDataWidth/8-1:0] be;
        logic [RtDataWidth-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic [RtDataWidth-1:0] rdata;
        logic                   err;
    } obi_rsp_t;

    // Round-robin successor, wrapping n-1 back to 0
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rt_id_fifo.sv
// rtl/rt_id_fifo.sv - in-order issuer ID FIFO for outstanding bus transactions
module rt_id_fifo #(
    parameter  int unsigned Depth    = 4,
    parameter  int unsigned Width    = 1,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                push_eff, pop_eff;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot, so push is accepted when full if a pop happens too
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    // Pointer wrap and fill-level update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, flushed asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rt_sba_obi_arbiter.sv
// rtl/rt_sba_obi_arbiter.sv - round-robin OBI arbiter with in-order response routing
module rt_sba_obi_arbiter
    import rt_pkg::*;
#(
    parameter  int unsigned NumReq         = RtNumReq,
    parameter  int unsigned AddrWidth      = RtAddrWidth,
    parameter  int unsigned DataWidth      = RtDataWidth,
    parameter  int unsigned MaxOutstanding = RtMaxOutstanding,
    localparam int unsigned BeWidth        = DataWidth / 8,
    localparam int unsigned IdWidth        = $clog2(NumReq),
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NumReq-1:0]           sbr_req_i,
    output logic [NumReq-1:0]           sbr_gnt_o,
    input  logic [NumReq*AddrWidth-1:0] sbr_addr_i,
    input  logic [NumReq-1:0]           sbr_we_i,
    input  logic [NumReq*BeWidth-1:0]   sbr_be_i,
    input  logic [NumReq*DataWidth-1:0] sbr_wdata_i,
    output logic [NumReq-1:0]           sbr_rvalid_o,
    output logic [DataWidth-1:0]        sbr_rdata_o,
    output logic                        sbr_err_o,
    output logic                        mgr_req_o,
    input  logic                        mgr_gnt_i,
    output logic [AddrWidth-1:0]        mgr_addr_o,
    output logic                        mgr_we_o,
    output logic [BeWidth-1:0]          mgr_be_o,
    output logic [DataWidth-1:0]        mgr_wdata_o,
    input  logic                        mgr_rvalid_i,
    input  logic [DataWidth-1:0]        mgr_rdata_i,
    input  logic                        mgr_err_i,
    output logic [CntWidth-1:0]         outstanding_o,
    output logic                        unexp_rsp_o
);

    logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0] sel_q, sel_d;
    logic               lock_q, lock_d;
    logic               unexp_q, unexp_d;
    logic [IdWidth-1:0] arb_sel;
    logic [IdWidth-1:0] sel;
    logic               handshake;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [IdWidth-1:0] head_id;

    // Round-robin search starting at the pointer; first asserted request wins
    always_comb begin
        int unsigned cand;
        logic        found;
        arb_sel = rr_ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(rr_ptr_q) + i) % NumReq;
            if (!found && sbr_req_i[IdWidth'(cand)]) begin
                found   = 1'b1;
                arb_sel = IdWidth'(cand);
            end
        end
    end

    // A stalled request keeps its winner so the manager sees a stable address phase
    assign sel       = lock_q ? sel_q : arb_sel;
    assign mgr_req_o = (|sbr_req_i) & ~fifo_full;
    assign handshake = mgr_req_o & mgr_gnt_i;
    assign fifo_pop  = mgr_rvalid_i & ~fifo_empty;

    assign mgr_addr_o  = sbr_addr_i[32'(sel)*AddrWidth +: AddrWidth];
    assign mgr_we_o    = sbr_we_i[sel];
    assign mgr_be_o    = sbr_be_i[32'(sel)*BeWidth +: BeWidth];
    assign mgr_wdata_o = sbr_wdata_i[32'(sel)*DataWidth +: DataWidth];

    assign sbr_rdata_o   = mgr_rdata_i;
    assign sbr_err_o     = mgr_err_i;
    assign unexp_rsp_o   = unexp_q;

    // Grant and response-valid fan-out to the selected / oldest requester
    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (handshake) begin
            sbr_gnt_o[sel] = 1'b1;
        end
        if (fifo_pop) begin
            sbr_rvalid_o[head_id] = 1'b1;
        end
    end

    // Next-state for pointer, lock and sticky unexpected-response flag
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        lock_d   = lock_q;
        unexp_d  = unexp_q | (mgr_rvalid_i & fifo_empty);
        if (handshake) begin
            rr_ptr_d = IdWidth'(rr_next(32'(sel), NumReq));
            lock_d   = 1'b0;
        end else if (mgr_req_o) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            lock_q   <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            unexp_q  <= unexp_d;
        end
    end

    rt_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdWidth)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (fifo_pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // A locked requester must hold its request until granted
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n) lock_q |-> sbr_req_i[sel_q]);

endmodule

// File: tb/tb_rt_sba_obi_arbiter.sv
// tb/tb_rt_sba_obi_arbiter.sv - self-checking bench for rt_sba_obi_arbiter
module tb_rt_sba_obi_arbiter;
    import rt_pkg::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    sbr_req_i;
    logic [NR-1:0]    sbr_gnt_o;
    logic [NR*AW-1:0] sbr_addr_i;
    logic [NR-1:0]    sbr_we_i;
    logic [NR*BW-1:0] sbr_be_i;
    logic [NR*DW-1:0] sbr_wdata_i;
    logic [NR-1:0]    sbr_rvalid_o;
    logic [DW-1:0]    sbr_rdata_o;
    logic             sbr_err_o;
    logic             mgr_req_o;
    logic             mgr_gnt_i;
    logic [AW-1:0]    mgr_addr_o;
    logic             mgr_we_o;
    logic [BW-1:0]    mgr_be_o;
    logic [DW-1:0]    mgr_wdata_o;
    logic             mgr_rvalid_i;
    logic [DW-1:0]    mgr_rdata_i;
    logic             mgr_err_i;
    logic [CW-1:0]    outstanding_o;
    logic             unexp_rsp_o;

    rt_sba_obi_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
        .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
        .sbr_rvalid_o(sbr_rvalid_o), .sbr_rdata_o(sbr_rdata_o), .sbr_err_o(sbr_err_o),
        .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
        .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
        .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i),
        .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  e_gnt;
        logic        e_mreq;
        logic [1:0]  e_rv;
        int          e_out;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic [31:0] rdata,
                                logic err, logic [1:0] e_gnt, logic e_mreq, logic [1:0] e_rv,
                                int e_out);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_rv = e_rv; v.e_out = e_out;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        sbr_req_i    = '0;
        sbr_addr_i   = '0;
        sbr_we_i     = '0;
        sbr_be_i     = '0;
        sbr_wdata_i  = '0;
        mgr_gnt_i    = 1'b0;
        mgr_rvalid_i = 1'b0;
        mgr_rdata_i  = '0;
        mgr_err_i    = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic we,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd);
        sbr_addr_i[i*AW +: AW]  = a;
        sbr_we_i[i]             = we;
        sbr_be_i[i*BW +: BW]    = be;
        sbr_wdata_i[i*DW +: DW] = wd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Back-to-back alternation to full, drain, then interleaved issue with err on 2nd
        tbl[0]  = mk(2'b11, 1, 0, 32'h0, 0, 2'b01, 1, 2'b00, 0);
        tbl[1]  = mk(2'b11, 1, 0, 32'h0, 0, 2'b10, 1, 2'b00, 1);
        tbl[2]  = mk(2'b11, 1, 0, 32'h0, 0, 2'b01, 1, 2'b00, 2);
        tbl[3]  = mk(2'b11, 1, 0, 32'h0, 0, 2'b10, 1, 2'b00, 3);
        tbl[4]  = mk(2'b00, 1, 1, 32'h1, 0, 2'b00, 0, 2'b01, 4);
        tbl[5]  = mk(2'b00, 1, 1, 32'h2, 1, 2'b00, 0, 2'b10, 3);
        tbl[6]  = mk(2'b00, 1, 1, 32'h3, 0, 2'b00, 0, 2'b01, 2);
        tbl[7]  = mk(2'b00, 1, 1, 32'h4, 0, 2'b00, 0, 2'b10, 1);
        tbl[8]  = mk(2'b00, 0, 0, 32'h0, 0, 2'b00, 0, 2'b00, 0);
        tbl[9]  = mk(2'b10, 1, 0, 32'h0, 0, 2'b10, 1, 2'b00, 0);
        tbl[10] = mk(2'b01, 1, 0, 32'h0, 0, 2'b01, 1, 2'b00, 1);
        tbl[11] = mk(2'b10, 1, 0, 32'h0, 0, 2'b10, 1, 2'b00, 2);
        tbl[12] = mk(2'b00, 0, 1, 32'hA, 0, 2'b00, 0, 2'b10, 3);
        tbl[13] = mk(2'b00, 0, 1, 32'hB, 1, 2'b00, 0, 2'b01, 2);
        tbl[14] = mk(2'b00, 0, 1, 32'hC, 0, 2'b00, 0, 2'b10, 1);
        tbl[15] = mk(2'b00, 0, 0, 32'h0, 0, 2'b00, 0, 2'b00, 0);

        // Reset and a single read
        do_reset();
        #3;
        chk("rst_gnt", 64'(sbr_gnt_o), 0);
        chk("rst_rvalid", 64'(sbr_rvalid_o), 0);
        chk("rst_mreq", 64'(mgr_req_o), 0);
        chk("rst_out", 64'(outstanding_o), 0);
        chk("rst_unexp", 64'(unexp_rsp_o), 0);
        tick();
        sbr_req_i[0] = 1'b1;
        set_port(0, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
        mgr_gnt_i = 1'b1;
        #3;
        chk("t1_gnt", 64'(sbr_gnt_o), 64'b01);
        chk("t1_addr", 64'(mgr_addr_o), 64'h1000);
        tick();
        idle_inputs();
        #3;
        chk("t1_out", 64'(outstanding_o), 1);
        tick();
        mgr_rvalid_i = 1'b1;
        mgr_rdata_i  = 32'hDEAD_BEEF;
        #3;
        chk("t1_rvalid", 64'(sbr_rvalid_o), 64'b01);
        chk("t1_rdata", 64'(sbr_rdata_o), 64'hDEAD_BEEF);
        chk("t1_err", 64'(sbr_err_o), 0);
        tick();
        idle_inputs();

        // Table-driven vectors
        do_reset();
        set_port(0, 32'h100, 1'b0, 4'hF, 32'h0);
        set_port(1, 32'h200, 1'b1, 4'h3, 32'h55);
        for (int k = 0; k < 16; k++) begin
            sbr_req_i    = tbl[k].req;
            mgr_gnt_i    = tbl[k].gnt;
            mgr_rvalid_i = tbl[k].rv;
            mgr_rdata_i  = tbl[k].rdata;
            mgr_err_i    = tbl[k].err;
            #3;
            chk($sformatf("v%0d_gnt", k), 64'(sbr_gnt_o), 64'(tbl[k].e_gnt));
            chk($sformatf("v%0d_mreq", k), 64'(mgr_req_o), 64'(tbl[k].e_mreq));
            chk($sformatf("v%0d_rvalid", k), 64'(sbr_rvalid_o), 64'(tbl[k].e_rv));
            chk($sformatf("v%0d_out", k), 64'(outstanding_o), 64'(tbl[k].e_out));
            chk($sformatf("v%0d_err", k), 64'(sbr_err_o), 64'(tbl[k].err));
            if (tbl[k].e_gnt != 2'b00)
                chk($sformatf("v%0d_addr", k), 64'(mgr_addr_o),
                    tbl[k].e_gnt[0] ? 64'h100 : 64'h200);
            tick();
        end
        idle_inputs();

        // Lock holds req0 against a higher-priority req1
        do_reset();
        sbr_req_i[0] = 1'b1;
        set_port(0, 32'h80, 1'b0, 4'hF, 32'h0);
        mgr_gnt_i = 1'b1;
        tick();
        set_port(0, 32'h100, 1'b0, 4'hF, 32'h0);
        set_port(1, 32'h200, 1'b0, 4'hF, 32'h0);
        mgr_gnt_i = 1'b0;
        #3;
        chk("t3_c0_addr", 64'(mgr_addr_o), 64'h100);
        chk("t3_c0_gnt", 64'(sbr_gnt_o), 0);
        tick();
        sbr_req_i[1] = 1'b1;
        for (int c = 1; c < 3; c++) begin
            #3;
            chk($sformatf("t3_c%0d_addr", c), 64'(mgr_addr_o), 64'h100);
            chk($sformatf("t3_c%0d_gnt", c), 64'(sbr_gnt_o), 0);
            tick();
        end
        mgr_gnt_i = 1'b1;
        #3;
        chk("t3_c3_gnt", 64'(sbr_gnt_o), 64'b01);
        chk("t3_c3_addr", 64'(mgr_addr_o), 64'h100);
        tick();
        sbr_req_i[0] = 1'b0;
        #3;
        chk("t3_c4_gnt", 64'(sbr_gnt_o), 64'b10);
        chk("t3_c4_addr", 64'(mgr_addr_o), 64'h200);
        tick();
        idle_inputs();

        // Fill to MaxOutstanding, then a pop reopens issue one cycle later
        do_reset();
        sbr_req_i[0] = 1'b1;
        mgr_gnt_i    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_port(0, 32'h4000 + 32'(c * 4), 1'b1, 4'hF, 32'(c));
            #3;
            chk($sformatf("t4_w%0d_gnt", c), 64'(sbr_gnt_o), 64'b01);
            chk($sformatf("t4_w%0d_we", c), 64'(mgr_we_o), 1);
            tick();
        end
        #3;
        chk("t4_full_out", 64'(outstanding_o), 4);
        chk("t4_full_mreq", 64'(mgr_req_o), 0);
        chk("t4_full_gnt", 64'(sbr_gnt_o), 0);
        tick();
        mgr_rvalid_i = 1'b1;
        #3;
        chk("t4_pop_mreq", 64'(mgr_req_o), 0);
        chk("t4_pop_gnt", 64'(sbr_gnt_o), 0);
        chk("t4_pop_rvalid", 64'(sbr_rvalid_o), 64'b01);
        tick();
        mgr_rvalid_i = 1'b0;
        #3;
        chk("t4_resume_out", 64'(outstanding_o), 3);
        chk("t4_resume_mreq", 64'(mgr_req_o), 1);
        chk("t4_resume_gnt", 64'(sbr_gnt_o), 64'b01);
        tick();
        idle_inputs();

        // Unexpected response, sticky flag, asynchronous reset mid-burst
        do_reset();
        mgr_rvalid_i = 1'b1;
        #3;
        chk("t6_rvalid", 64'(sbr_rvalid_o), 0);
        tick();
        mgr_rvalid_i = 1'b0;
        #3;
        chk("t6_unexp", 64'(unexp_rsp_o), 1);
        tick();
        #3;
        chk("t6_sticky", 64'(unexp_rsp_o), 1);
        tick();
        sbr_req_i[0] = 1'b1;
        set_port(0, 32'h300, 1'b0, 4'hF, 32'h0);
        mgr_gnt_i = 1'b1;
        tick();
        tick();
        mgr_gnt_i = 1'b0;
        #3;
        chk("t6_pre_out", 64'(outstanding_o), 2);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("t6_rst_out", 64'(outstanding_o), 0);
        chk("t6_rst_unexp", 64'(unexp_rsp_o), 0);
        chk("t6_rst_mreq", 64'(mgr_req_o), 0);
        chk("t6_rst_gnt", 64'(sbr_gnt_o), 0);
        tick();
        rst_n = 1'b1;
        mgr_rvalid_i = 1'b1;
        #3;
        chk("t6_late_rvalid", 64'(sbr_rvalid_o), 0);
        tick();
        mgr_rvalid_i = 1'b0;
        #3;
        chk("t6_late_unexp", 64'(unexp_rsp_o), 1);
        tick();

        // Randomized traffic against a queue-based reference model
        do_reset();
        begin
            int            q[$];
            int            rr;
            int            lk;
            bit            m_unexp;
            bit            pend [NR];
            logic [AW-1:0] ma [NR];
            logic          mwe [NR];
            logic [BW-1:0] mbe [NR];
            logic [DW-1:0] mwd [NR];
            rr = 0; lk = -1; m_unexp = 0;
            for (int i = 0; i < NR; i++) pend[i] = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                bit            full, anyr, e_mreq;
                int            sel;
                logic [NR-1:0] e_gnt, e_rv;
                for (int i = 0; i < NR; i++) begin
                    if (!pend[i]) begin
                        sbr_req_i[i] = 1'($urandom % 2);
                        ma[i]  = $urandom;
                        mwe[i] = 1'($urandom % 2);
                        mbe[i] = BW'($urandom);
                        mwd[i] = $urandom;
                        set_port(i, ma[i], mwe[i], mbe[i], mwd[i]);
                    end
                end
                mgr_gnt_i    = ($urandom % 4) != 0;
                mgr_rvalid_i = (q.size() > 0) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
                mgr_rdata_i  = $urandom;
                mgr_err_i    = 1'($urandom % 2);

                full   = (q.size() >= MO);
                anyr   = (sbr_req_i != '0);
                e_mreq = anyr && !full;
                sel    = 0;
                if (lk >= 0) sel = lk;
                else begin
                    for (int k = NR - 1; k >= 0; k--)
                        if (sbr_req_i[(rr + k) % NR]) sel = (rr + k) % NR;
                end
                e_gnt = (e_mreq && mgr_gnt_i) ? NR'(1 << sel) : '0;
                e_rv  = (mgr_rvalid_i && q.size() > 0) ? NR'(1 << q[0]) : '0;

                #3;
                chk("r_mreq", 64'(mgr_req_o), 64'(e_mreq));
                chk("r_gnt", 64'(sbr_gnt_o), 64'(e_gnt));
                chk("r_rvalid", 64'(sbr_rvalid_o), 64'(e_rv));
                chk("r_out", 64'(outstanding_o), 64'(q.size()));
                chk("r_unexp", 64'(unexp_rsp_o), 64'(m_unexp));
                chk("r_rdata", 64'(sbr_rdata_o), 64'(mgr_rdata_i));
                if (e_mreq) begin
                    chk("r_addr", 64'(mgr_addr_o), 64'(ma[sel]));
                    chk("r_we", 64'(mgr_we_o), 64'(mwe[sel]));
                    chk("r_be", 64'(mgr_be_o), 64'(mbe[sel]));
                    chk("r_wdata", 64'(mgr_wdata_o), 64'(mwd[sel]));
                end

                if (mgr_rvalid_i) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else m_unexp = 1;
                end
                if (e_mreq && mgr_gnt_i) begin
                    q.push_back(sel);
                    rr = (sel + 1) % NR;
                    lk = -1;
                end else if (e_mreq) begin
                    lk = sel;
                end
                for (int i = 0; i < NR; i++) pend[i] = sbr_req_i[i] && !e_gnt[i];
                tick();
            end
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
